// File: rtl/mux_bus_if.sv
// Handshake and pad-side signals of the multiplexed address/data bus engine.
`timescale 1ns/1ps
interface mux_bus_if #(parameter int DATA_W = 8);
    logic              req;
    logic              rnw;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ad_in;
    logic [DATA_W-1:0] ADout;
    logic              ad_oe;
    logic              ad;
    logic              cs;
    logic              wr;
    logic              rd;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  req, rnw, addr, wdata, ad_in,
        output ADout, ad_oe, ad, cs, wr, rd, busy, done, rdata
    );

    modport slave (
        output req, rnw, addr, wdata, ad_in,
        input  ADout, ad_oe, ad, cs, wr, rd, busy, done, rdata
    );
endinterface

// File: rtl/mux_bus_master.sv
// Single read/write transaction engine for an Intel-style multiplexed AD bus.
// Optional MUX_BUS_RDATA_SYNC_EN: 2-flop ad_in synchroniser, read strobe stretched by 2.
`timescale 1ns/1ps
module mux_bus_master #(
    parameter int DATA_W = 8,
    parameter int T_STB  = 5,
    parameter int T_HOLD = 2,
    parameter int T_GAP  = 8
) (
    input  logic      clock,
    input  logic      reset,
    mux_bus_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, A_ALE, A_CS, A_STB, A_END, A_HOLD, A_GAP,
        D_CS, D_STB, D_END, D_HOLD, D_GAP
    } state_t;

    localparam logic [7:0] C_STB  = 8'(T_STB - 1);
    localparam logic [7:0] C_HOLD = 8'(T_HOLD - 1);
    localparam logic [7:0] C_GAP  = 8'(T_GAP - 1);
`ifdef MUX_BUS_RDATA_SYNC_EN
    // two extra strobe cycles cover the synchroniser latency
    localparam logic [7:0] C_RSTB = 8'(T_STB + 1);
`else
    localparam logic [7:0] C_RSTB = 8'(T_STB - 1);
`endif

    state_t            state, nstate;
    logic [7:0]        cnt, cnt_nxt;
    logic              rnw_q;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic [DATA_W-1:0] cap_src;
    logic              last, capture;

    logic              ad_r, cs_r, wr_r, rd_r, oe_r, busy_r, done_r;
    logic [DATA_W-1:0] dout_r, rdata_r;
    logic              ad_n, cs_n, wr_n, rd_n, oe_n, busy_n, done_n;
    logic [DATA_W-1:0] dout_n;

`ifdef MUX_BUS_RDATA_SYNC_EN
    logic [DATA_W-1:0] ad_s1, ad_s2;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ad_s1 <= '0;
            ad_s2 <= '0;
        end else begin
            ad_s1 <= bus.ad_in;
            ad_s2 <= ad_s1;
        end
    end
    assign cap_src = ad_s2;
`else
    assign cap_src = bus.ad_in;
`endif

    function automatic logic [7:0] load_val(state_t s, logic r);
        case (s)
            A_STB:          load_val = C_STB;
            D_STB:          load_val = r ? C_RSTB : C_STB;
            A_HOLD, D_HOLD: load_val = C_HOLD;
            A_GAP, D_GAP:   load_val = C_GAP;
            default:        load_val = 8'd0;
        endcase
    endfunction

    assign last    = (cnt == 8'd0);
    assign capture = (state == D_STB) && last && rnw_q;

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (bus.req) nstate = A_ALE;
            A_ALE:   nstate = A_CS;
            A_CS:    nstate = A_STB;
            A_STB:   if (last) nstate = A_END;
            A_END:   nstate = A_HOLD;
            A_HOLD:  if (last) nstate = A_GAP;
            A_GAP:   if (last) nstate = D_CS;
            D_CS:    nstate = D_STB;
            D_STB:   if (last) nstate = D_END;
            D_END:   nstate = D_HOLD;
            D_HOLD:  if (last) nstate = D_GAP;
            D_GAP:   if (last) nstate = IDLE;
            default: nstate = IDLE;
        endcase

        if (nstate != state) cnt_nxt = load_val(nstate, rnw_q);
        else if (!last)      cnt_nxt = cnt - 8'd1;
        else                 cnt_nxt = cnt;

        // outputs are decoded from the next state so they register alongside it
        ad_n   = 1'b1;
        cs_n   = 1'b1;
        wr_n   = 1'b1;
        rd_n   = 1'b1;
        oe_n   = 1'b0;
        dout_n = '1;
        case (nstate)
            A_ALE: ad_n = 1'b0;
            A_CS: begin
                ad_n = 1'b0;
                cs_n = 1'b0;
            end
            A_STB: begin
                ad_n   = 1'b0;
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                oe_n   = 1'b1;
                dout_n = addr_q;
            end
            A_END: begin
                ad_n   = 1'b0;
                oe_n   = 1'b1;
                dout_n = addr_q;
            end
            A_HOLD: begin
                oe_n   = 1'b1;
                dout_n = addr_q;
            end
            D_CS: cs_n = 1'b0;
            D_STB: begin
                cs_n = 1'b0;
                if (rnw_q) rd_n = 1'b0;
                else begin
                    wr_n   = 1'b0;
                    oe_n   = 1'b1;
                    dout_n = wdata_q;
                end
            end
            D_END, D_HOLD: begin
                if (!rnw_q) begin
                    oe_n   = 1'b1;
                    dout_n = wdata_q;
                end
            end
            default: ;
        endcase
        busy_n = (nstate != IDLE);
        done_n = (state == D_GAP) && last;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ad_r    <= 1'b1;
            cs_r    <= 1'b1;
            wr_r    <= 1'b1;
            rd_r    <= 1'b1;
            oe_r    <= 1'b0;
            dout_r  <= '1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rdata_r <= '0;
        end else begin
            state  <= nstate;
            cnt    <= cnt_nxt;
            if (state == IDLE && bus.req) begin
                rnw_q   <= bus.rnw;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            ad_r   <= ad_n;
            cs_r   <= cs_n;
            wr_r   <= wr_n;
            rd_r   <= rd_n;
            oe_r   <= oe_n;
            dout_r <= dout_n;
            busy_r <= busy_n;
            done_r <= done_n;
            if (capture) rdata_r <= cap_src;
        end
    end

    assign bus.ad    = ad_r;
    assign bus.cs    = cs_r;
    assign bus.wr    = wr_r;
    assign bus.rd    = rd_r;
    assign bus.ad_oe = oe_r;
    assign bus.ADout = dout_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_mux_bus_master.sv
// Bench for mux_bus_master: table vectors, corner sequences and random transactions vs a schedule model.
`timescale 1ns/1ps
module tb_mux_bus_master;

`ifdef MUX_BUS_RDATA_SYNC_EN
    localparam int SYNC_X = 2;
`else
    localparam int SYNC_X = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rnw_i = 1'b0;
    logic [7:0] addr_i = 8'h00, wdata_i = 8'h00, adin_i = 8'h00;

    always #5 clock = ~clock;

    mux_bus_if #(.DATA_W(8)) bus0 ();
    mux_bus_if #(.DATA_W(8)) bus1 ();

    assign bus0.req = req0;   assign bus1.req = req1;
    assign bus0.rnw = rnw_i;  assign bus1.rnw = rnw_i;
    assign bus0.addr = addr_i;   assign bus1.addr = addr_i;
    assign bus0.wdata = wdata_i; assign bus1.wdata = wdata_i;
    assign bus0.ad_in = adin_i;  assign bus1.ad_in = adin_i;

    mux_bus_master #(.DATA_W(8), .T_STB(5), .T_HOLD(2), .T_GAP(8)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0));
    mux_bus_master #(.DATA_W(8), .T_STB(1), .T_HOLD(1), .T_GAP(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1));

    typedef struct packed {
        logic       ad, cs, wr, rd, ad_oe, busy, done;
        logic [7:0] dout;
    } obs_t;

    typedef struct {
        int         sel;
        logic       rnw;
        logic [7:0] addr, wdata, adin;
        int         len;
        logic [7:0] exp_rd;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mrd [2];

    function automatic obs_t idle_obs();
        obs_t o;
        o.ad = 1'b1; o.cs = 1'b1; o.wr = 1'b1; o.rd = 1'b1;
        o.ad_oe = 1'b0; o.busy = 1'b0; o.done = 1'b0; o.dout = 8'hFF;
        return o;
    endfunction

    // Expected pins t edges after the accept edge, from phase boundaries of the bus schedule
    function automatic obs_t model(int t, int len, logic rnw, logic [7:0] a, logic [7:0] wd,
                                   int T, int H, int dstb);
        obs_t o;
        int a_end, ds, de;
        int G;
        o = idle_obs();
        if (t >= len) begin
            o.done = (t == len);
            return o;
        end
        G = (len - 5 - T - dstb - 2 * H) / 2;
        a_end = 2 + T;
        ds = 4 + T + H + G;
        de = ds + dstb;
        o.busy = 1'b1;
        o.ad = !(t <= a_end);
        o.cs = !((t >= 1 && t < a_end) || (t >= ds - 1 && t < de));
        o.wr = !((t >= 2 && t < a_end) || (!rnw && t >= ds && t < de));
        o.rd = !(rnw && t >= ds && t < de);
        if (t >= 2 && t <= a_end + H) begin
            o.ad_oe = 1'b1; o.dout = a;
        end else if (!rnw && t >= ds && t <= de + H) begin
            o.ad_oe = 1'b1; o.dout = wd;
        end
        return o;
    endfunction

    function automatic obs_t get_obs(int sel);
        obs_t o;
        if (sel == 0) begin
            o.ad = bus0.ad; o.cs = bus0.cs; o.wr = bus0.wr; o.rd = bus0.rd;
            o.ad_oe = bus0.ad_oe; o.busy = bus0.busy; o.done = bus0.done; o.dout = bus0.ADout;
        end else begin
            o.ad = bus1.ad; o.cs = bus1.cs; o.wr = bus1.wr; o.rd = bus1.rd;
            o.ad_oe = bus1.ad_oe; o.busy = bus1.busy; o.done = bus1.done; o.dout = bus1.ADout;
        end
        return o;
    endfunction

    function automatic logic [7:0] get_rdata(int sel);
        return (sel == 0) ? bus0.rdata : bus1.rdata;
    endfunction

    task automatic chk_obs(string nm, obs_t act, obs_t exp);
        logic [6:0] af, ef;
        checks++;
        if (act !== exp) begin
            failures++;
            af = {act.ad, act.cs, act.wr, act.rd, act.ad_oe, act.busy, act.done};
            ef = {exp.ad, exp.cs, exp.wr, exp.rd, exp.ad_oe, exp.busy, exp.done};
            $display("FAIL %s actual ad,cs,wr,rd,oe,busy,done=%b ADout=%h required=%b ADout=%h",
                     nm, af, act.dout, ef, exp.dout);
        end
    endtask

    task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(int sel, logic v);
        if (sel == 0) req0 = v; else req1 = v;
    endtask

    // Starts at an idle cycle, returns in the done cycle (t == len)
    task automatic run_txn(int sel, logic rnw, logic [7:0] a, logic [7:0] wd, logic [7:0] din,
                           int len, logic [7:0] exp_rd, bit hold_req, bit pulse, string nm);
        int T, H, dstb, ds, G;
        T = (sel == 0) ? 5 : 1;
        H = (sel == 0) ? 2 : 1;
        G = (sel == 0) ? 8 : 1;
        dstb = T + (rnw ? SYNC_X : 0);
        ds = 4 + T + H + G;
        rnw_i = rnw; addr_i = a; wdata_i = wd; adin_i = 8'($urandom);
        drive_req(sel, 1'b1);
        for (int t = 0; t <= len; t++) begin
            tick();
            if (t == 0) begin
                if (!hold_req) drive_req(sel, 1'b0);
                rnw_i = 1'($urandom); addr_i = 8'($urandom); wdata_i = 8'($urandom);
            end
            if (pulse && t == 10) begin
                drive_req(sel, 1'b1);
                addr_i = 8'h99;
            end
            if (pulse && t == 12) drive_req(sel, 1'b0);
            adin_i = (t >= ds && t < ds + dstb) ? din : 8'($urandom);
            chk_obs($sformatf("%s t=%0d", nm, t), get_obs(sel), model(t, len, rnw, a, wd, T, H, dstb));
        end
        chk8({nm, " rdata"}, get_rdata(sel), exp_rd);
        mrd[sel] = get_rdata(sel);
        mrd[sel] = exp_rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [6];
        logic [7:0] b2b [4];
        int         rl0, rl1;
        rl0 = 35 + SYNC_X;
        rl1 = 11 + SYNC_X;
        vecs[0] = '{sel: 0, rnw: 1'b0, addr: 8'h43, wdata: 8'h00, adin: 8'h00, len: 35,  exp_rd: 8'h00};
        vecs[1] = '{sel: 0, rnw: 1'b1, addr: 8'h41, wdata: 8'h00, adin: 8'hA5, len: rl0, exp_rd: 8'hA5};
        vecs[2] = '{sel: 0, rnw: 1'b0, addr: 8'h42, wdata: 8'h5A, adin: 8'h00, len: 35,  exp_rd: 8'hA5};
        vecs[3] = '{sel: 0, rnw: 1'b1, addr: 8'h0D, wdata: 8'h00, adin: 8'h3C, len: rl0, exp_rd: 8'h3C};
        vecs[4] = '{sel: 1, rnw: 1'b0, addr: 8'h43, wdata: 8'h7E, adin: 8'h00, len: 11,  exp_rd: 8'h00};
        vecs[5] = '{sel: 1, rnw: 1'b1, addr: 8'h10, wdata: 8'h00, adin: 8'hC3, len: rl1, exp_rd: 8'hC3};
        b2b = '{8'h43, 8'h42, 8'h41, 8'hF2};
        mrd[0] = 8'h00;
        mrd[1] = 8'h00;

        // reset state
        repeat (3) tick();
        chk_obs("reset dut0", get_obs(0), idle_obs());
        chk_obs("reset dut1", get_obs(1), idle_obs());
        chk8("reset rdata", get_rdata(0), 8'h00);
        reset = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) begin
            run_txn(vecs[i].sel, vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].adin,
                    vecs[i].len, vecs[i].exp_rd, 1'b0, 1'b0, $sformatf("vec%0d", i));
            tick();
            chk_obs($sformatf("vec%0d idle after done", i), get_obs(vecs[i].sel), idle_obs());
        end

        // reset in idle clears captured read data
        tick();
        reset = 1'b0;
        #1;
        chk_obs("idle reset pins", get_obs(0), idle_obs());
        chk8("idle reset rdata0", get_rdata(0), 8'h00);
        chk8("idle reset rdata1", get_rdata(1), 8'h00);
        mrd[0] = 8'h00; mrd[1] = 8'h00;
        tick();
        reset = 1'b1;
        tick();

        // reset during the address strobe aborts immediately
        run_txn(0, 1'b1, 8'h41, 8'h00, 8'h77, rl0, 8'h77, 1'b0, 1'b0, "pre-abort read");
        tick();
        rnw_i = 1'b0; addr_i = 8'h43; wdata_i = 8'h00; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        repeat (3) tick();
        chk_obs("mid A_STB", get_obs(0), model(3, 35, 1'b0, 8'h43, 8'h00, 5, 2, 5));
        reset = 1'b0;
        #1;
        chk_obs("abort pins", get_obs(0), idle_obs());
        chk8("abort rdata", get_rdata(0), 8'h00);
        mrd[0] = 8'h00;
        tick();
        reset = 1'b1;
        tick();
        run_txn(0, 1'b1, 8'h41, 8'h00, 8'hA5, rl0, 8'hA5, 1'b0, 1'b0, "post-abort read");
        tick();

        // req held high: each write accepted in the previous done cycle
        foreach (b2b[i])
            run_txn(0, 1'b0, b2b[i], 8'(i * 17), 8'h00, 35, mrd[0], 1'b1, 1'b0, $sformatf("b2b%0d", i));
        req0 = 1'b0;
        tick();
        chk_obs("b2b idle", get_obs(0), idle_obs());

        // a req pulse mid-transaction must not start another one
        run_txn(0, 1'b0, 8'h43, 8'h11, 8'h00, 35, mrd[0], 1'b0, 1'b1, "pulse");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_obs($sformatf("pulse idle %0d", k), get_obs(0), idle_obs());
        end

        // random transactions
        for (int n = 0; n < 20; n++) begin
            logic       r;
            logic [7:0] a, wd, din, er;
            r = 1'($urandom); a = 8'($urandom); wd = 8'($urandom); din = 8'($urandom);
            er = r ? din : mrd[0];
            run_txn(0, r, a, wd, din, 35 + (r ? SYNC_X : 0), er, 1'b0, 1'b0, $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
